// File: rtl/stream_source_mc.sv
// stream_source_mc: multi-channel val/rdy test source streaming preloaded messages per channel.
// Optional LFSR-driven idle gaps before each message stress the consumer.
module stream_source_mc #(
    parameter int          p_width     = 32,
    parameter int          p_nmsgs     = 16,
    parameter int          p_nchannels = 2,
    parameter int          p_max_delay = 3,
    parameter logic [15:0] p_seed      = 16'hACE1
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic                                          go_i,
    input  logic                                          rand_en_i,
    input  logic [p_nchannels*$clog2(p_nmsgs+1)-1:0]      len_i,
    output logic [p_nchannels-1:0]                        val_o,
    input  logic [p_nchannels-1:0]                        rdy_i,
    output logic [p_nchannels*p_width-1:0]                msg_o,
    output logic [p_nchannels-1:0]                        done_o,
    output logic                                          all_done_o
);
    localparam int LW = $clog2(p_nmsgs + 1);
    localparam int IW = p_nmsgs > 1 ? $clog2(p_nmsgs) : 1;
    localparam int AW = p_nchannels * p_nmsgs > 1 ? $clog2(p_nchannels * p_nmsgs) : 1;
    localparam int GW = $clog2(p_max_delay + 2);
    typedef enum logic [1:0] {IDLE, DELAY, SEND, DONE} state_t;
    logic [p_width-1:0] mem [p_nchannels*p_nmsgs];
    assign all_done_o = &done_o;
    for (genvar c = 0; c < p_nchannels; c++) begin : g_ch
        localparam logic [15:0] SEED = (p_seed ^ 16'(c)) == 16'd0 ? 16'h0001 : p_seed ^ 16'(c);
        localparam logic [AW-1:0] BASE = AW'(c * p_nmsgs);
        state_t             state_q, state_d;
        logic [IW-1:0]      idx_q, idx_d;
        logic [LW-1:0]      len_q, len_d, len_in;
        logic [GW-1:0]      gap_q, gap_d, gap_new;
        logic [15:0]        lfsr_q, lfsr_d;
        logic [p_width-1:0] msg_q, msg_d;
        logic               val_q, done_q;
        assign len_in  = len_i[c*LW +: LW] > LW'(p_nmsgs) ? LW'(p_nmsgs) : len_i[c*LW +: LW];
        assign gap_new = rand_en_i ? GW'(lfsr_q % 16'(p_max_delay + 1)) : '0;
        assign lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        always_comb begin
            state_d = state_q;
            idx_d   = idx_q;
            len_d   = len_q;
            gap_d   = gap_q;
            case (state_q)
                IDLE: if (go_i) begin
                    len_d   = len_in;
                    idx_d   = '0;
                    gap_d   = gap_new;
                    state_d = len_in == '0 ? DONE : gap_new == '0 ? SEND : DELAY;
                end
                DELAY: begin
                    gap_d   = gap_q - GW'(1);
                    state_d = gap_q == GW'(1) ? SEND : DELAY;
                end
                SEND: if (rdy_i[c]) begin
                    if (LW'(idx_q) == len_q - LW'(1)) state_d = DONE;
                    else begin
                        idx_d   = idx_q + IW'(1);
                        gap_d   = gap_new;
                        state_d = gap_new == '0 ? SEND : DELAY;
                    end
                end
                default: ;
            endcase
            // msg is registered from the next index so it lines up with val
            msg_d = state_d == SEND ? mem[BASE + AW'(idx_d)] : '0;
        end
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                state_q <= IDLE;
                idx_q   <= '0;
                len_q   <= '0;
                gap_q   <= '0;
                lfsr_q  <= SEED;
                msg_q   <= '0;
                val_q   <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                idx_q   <= idx_d;
                len_q   <= len_d;
                gap_q   <= gap_d;
                lfsr_q  <= lfsr_d;
                msg_q   <= msg_d;
                val_q   <= state_d == SEND;
                done_q  <= state_d == DONE;
            end
        end
        assign val_o[c]                  = val_q;
        assign done_o[c]                 = done_q;
        assign msg_o[c*p_width +: p_width] = msg_q;
    end
endmodule

// File: tb/tb_stream_source_mc.sv
// tb_stream_source_mc: randomized scoreboard bench for stream_source_mc.
// Each channel's expected stream is simply mem[c*N + 0 .. min(len,N)-1] in order.
module tb_stream_source_mc;
    localparam int W  = 32;
    localparam int N  = 16;
    localparam int C  = 2;
    localparam int D  = 3;
    localparam int LW = $clog2(N + 1);
    logic            clk = 1'b0;
    logic            rst, go, rand_en, all_done;
    logic [C*LW-1:0] len;
    logic [C-1:0]    val, rdy, done;
    logic [C*W-1:0]  msg;
    logic [W-1:0]    mdl [C*N];
    int              nvec = 0;
    int              nerr = 0;

    always #5 clk = ~clk;

    stream_source_mc #(.p_width(W), .p_nmsgs(N), .p_nchannels(C), .p_max_delay(D), .p_seed(16'hACE1)) dut (
        .clk_i(clk), .reset_i(rst), .go_i(go), .rand_en_i(rand_en), .len_i(len),
        .val_o(val), .rdy_i(rdy), .msg_o(msg), .done_o(done), .all_done_o(all_done)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reset is asserted away from any clock edge, so its effect must be immediate
    task automatic do_reset();
        go  = 1'b0;
        rdy = '0;
        rst = 1'b1;
        #2;
        chk("rst_val", W'(val), 0);
        chk("rst_done", W'(done), 0);
        chk("rst_msg0", msg[0 +: W], 0);
        chk("rst_msg1", msg[W +: W], 0);
        chk("rst_all_done", W'(all_done), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input bit spec_vals);
        for (int i = 0; i < C*N; i++) begin
            mdl[i] = $urandom;
            if (spec_vals && i == 0) mdl[i] = 32'h000F000A;
            if (spec_vals && i == 1) mdl[i] = 32'h0016000A;
            if (spec_vals && i == 2) mdl[i] = 32'h00240012;
            if (spec_vals && i == 3) mdl[i] = 32'h00240015;
            dut.mem[i] = mdl[i];
        end
    endtask

    // rmode: 0 rdy always high, 1 pattern 1,0,0,..., 2 random; stop_after>=0 aborts once ch0 sent that many
    task automatic run(input int l0, input int l1, input bit re, input int rmode, input int stop_after);
        int           n [C];
        int           cnt [C];
        int           idle [C];
        bit           held [C];
        logic [W-1:0] last [C];
        logic [W-1:0] m;
        logic [C-1:0] r;
        bit           fin;
        int           k;
        k = 0;
        n[0] = l0 > N ? N : l0;
        n[1] = l1 > N ? N : l1;
        for (int c = 0; c < C; c++) begin
            cnt[c] = 0; idle[c] = 0; held[c] = 0; last[c] = '0;
        end
        len     = {LW'(l1), LW'(l0)};
        rand_en = re;
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1;
        go  = 1'b0;
        len = C*LW'($urandom);
        forever begin
            for (int c = 0; c < C; c++) begin
                m = msg[c*W +: W];
                chk("done", W'(done[c]), W'(cnt[c] == n[c]));
                if (held[c]) begin
                    chk("hold_val", W'(val[c]), 1);
                    chk("hold_msg", m, last[c]);
                end
                if (val[c]) begin
                    chk("val_allowed", W'(cnt[c] < n[c]), 1);
                    if (cnt[c] < n[c]) chk("msg_order", m, mdl[c*N + cnt[c]]);
                    chk("gap_bound", W'(idle[c] <= (re ? D : 0)), 1);
                end else begin
                    chk("msg_zero", m, 0);
                    if (cnt[c] < n[c]) idle[c]++;
                end
            end
            fin = cnt[0] == n[0] && cnt[1] == n[1];
            chk("all_done", W'(all_done), W'(fin));
            if (fin || (stop_after >= 0 && cnt[0] >= stop_after)) break;
            if (k > 600) begin
                chk("timeout", 0, 1);
                break;
            end
            r   = rmode == 0 ? '1 : rmode == 1 ? ((k % 3 == 0) ? '1 : '0) : C'($urandom);
            rdy = r;
            for (int c = 0; c < C; c++) begin
                m       = msg[c*W +: W];
                held[c] = val[c] && !r[c];
                last[c] = m;
                if (val[c] && r[c] && cnt[c] < n[c]) begin
                    cnt[c]++;
                    idle[c] = 0;
                end
            end
            k++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; rand_en = 1'b0; len = '0; rdy = '0;
        do_reset();
        load(1);
        run(4, 0, 0, 0, -1);
        go = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        go = 1'b0;
        chk("done_sticky", W'(done), 2'b11);
        chk("done_no_val", W'(val), 0);
        do_reset();
        load(0);
        run(6, 3, 0, 1, -1);
        do_reset();
        load(0);
        run(3, 5, 1, 0, -1);
        do_reset();
        load(0);
        run(3, 5, 1, 2, -1);
        do_reset();
        load(0);
        run(0, 2, 0, 2, -1);
        do_reset();
        load(1);
        run(4, 4, 0, 0, 2);
        do_reset();
        run(4, 4, 0, 0, -1);
        do_reset();
        load(0);
        run(20, 16, 0, 0, -1);
        repeat (20) begin
            do_reset();
            load(0);
            run($urandom_range(20), $urandom_range(20), 1'($urandom), $urandom_range(2), -1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
